// File: rtl/ysyx_24100027_mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, divider
// FSM states and default widths.
package ysyx_24100027_mdu_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } div_state_e;

   // op[0] clear selects the signed variants, op[1] set selects the remainder
   function automatic logic op_is_signed(input logic [1:0] op_v);
      return ~op_v[0];
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op_v);
      return op_v[1];
   endfunction

endpackage

// File: rtl/ysyx_24100027_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module ysyx_24100027_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN:0]   rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;

   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {2'b00, dvs_i};
      if (!diff[XLEN+1]) begin
         rem_o = diff[XLEN:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ysyx_24100027_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready
// request and response ports; one operation in flight at a time.
module ysyx_24100027_divider
   import ysyx_24100027_mdu_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   // state  | meaning
   // S_IDLE | waiting for a request, in_ready high
   // S_BUSY | one restoring step per cycle, XLEN steps
   // S_DONE | result held until the consumer takes it

   div_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            is_rem_q, is_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;

   logic [XLEN:0]   step_rem;
   logic [XLEN-1:0] step_quo;
   logic            signed_op, sign_a, sign_b, div_zero, ovf;
   logic [XLEN-1:0] mag_a, mag_b, quo_fix, rem_fix;

   ysyx_24100027_div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      signed_op = op_is_signed(op);
      sign_a    = signed_op & a[XLEN-1];
      sign_b    = signed_op & b[XLEN-1];
      // -0x80000000 wraps back to 0x80000000, which is the wanted magnitude
      mag_a     = sign_a ? -a : a;
      mag_b     = sign_b ? -b : b;
      div_zero  = (b == '0);
      ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

      quo_fix   = neg_quo_q ? -step_quo : step_quo;
      rem_fix   = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               is_rem_d  = op_is_rem(op);
               neg_quo_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               rem_d     = '0;
               quo_d     = mag_a;
               dvs_d     = mag_b;
               cnt_d     = '0;
               if (div_zero) begin
                  result_d = op_is_rem(op) ? a : '1;
                  state_d  = S_DONE;
               end else if (ovf) begin
                  result_d = op_is_rem(op) ? '0 : a;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
               result_d = is_rem_q ? rem_fix : quo_fix;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (kill) begin
         state_d  = S_IDLE;
         result_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;

endmodule
